// File: rtl/exec_stage.sv
// exec_stage: execute stage of the 8-bit pipeline -- ALU, load/store, 8-step shift-add multiply.
// Optional operand forwarding from the writeback register is enabled by defining EXEC_FWD_EN.
module exec_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int DM_AW  = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  input  logic [REG_AW-1:0] dest,
  input  logic [DM_AW-1:0]  dmaddr,
  output logic [DM_AW-1:0]  dm_addr,
  output logic              dm_we,
  output logic              dm_re,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_write,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SHL   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_SHR   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_MOV   = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(12);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, MUL_BUSY} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mul_a, mul_b, acc, mul_sum;
  logic [REG_AW-1:0] pend_dest;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              accept, is_alu;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_alu   = (opcode >= OP_ADD) && (opcode <= OP_MOV);

`ifdef EXEC_FWD_EN
  // The register file reads combinationally, so a value being written this cycle is not yet visible.
  assign op_a = (wb_write && (wb_reg == src_a)) ? wb_data : operand_a;
  assign op_b = (wb_write && (wb_reg == src_b)) ? wb_data : operand_b;
`else
  logic unused_src;
  assign unused_src = ^{src_a, src_b};
  assign op_a = operand_a;
  assign op_b = operand_b;
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: {alu_c, alu_res} = {op_a, 1'b0};
      OP_SHR: {alu_res, alu_c} = {1'b0, op_a};
      OP_MOV: alu_res = op_a;
      default: ;
    endcase
  end

  // One multiplier bit per cycle: multiplicand shifts left, multiplier shifts right.
  assign mul_sum = acc + (mul_b[0] ? mul_a : '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && (opcode == OP_LOAD)) state_next = LOAD_WAIT;
        else if (accept && (opcode == OP_MUL)) state_next = MUL_BUSY;
      end
      LOAD_WAIT: state_next = IDLE;
      MUL_BUSY:  if (cnt == CNT_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      pend_dest <= '0;
      dm_addr   <= '0;
      dm_we     <= 1'b0;
      dm_re     <= 1'b0;
      dm_wdata  <= '0;
      wb_write  <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      wb_write <= 1'b0;
      dm_we    <= 1'b0;
      dm_re    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_alu) begin
              wb_write <= 1'b1;
              wb_reg   <= dest;
              wb_data  <= alu_res;
              flag_z   <= (alu_res == '0);
              flag_c   <= alu_c;
            end else if (opcode == OP_LOAD) begin
              dm_re     <= 1'b1;
              dm_addr   <= dmaddr;
              pend_dest <= dest;
            end else if (opcode == OP_STORE) begin
              dm_we    <= 1'b1;
              dm_addr  <= dmaddr;
              dm_wdata <= op_a;
            end else if (opcode == OP_MUL) begin
              mul_a     <= op_a;
              mul_b     <= op_b;
              acc       <= '0;
              cnt       <= '0;
              pend_dest <= dest;
            end
          end
        end
        LOAD_WAIT: begin
          wb_write <= 1'b1;
          wb_reg   <= pend_dest;
          wb_data  <= dm_rdata;
        end
        MUL_BUSY: begin
          acc   <= mul_sum;
          mul_a <= {mul_a[DATA_W-2:0], 1'b0};
          mul_b <= {1'b0, mul_b[DATA_W-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            wb_write <= 1'b1;
            wb_reg   <= pend_dest;
            wb_data  <= mul_sum;
            flag_z   <= (mul_sum == '0);
            flag_c   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed literal cases plus randomized instruction stream
// compared every cycle against a cycle-indexed schedule of expected outputs.
module tb_exec_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcode = '0;
  logic [7:0] operand_a = '0, operand_b = '0;
  logic [2:0] src_a = '0, src_b = '0, dest = '0;
  logic [3:0] dmaddr = '0;
  logic [3:0] dm_addr;
  logic       dm_we, dm_re;
  logic [7:0] dm_wdata, dm_rdata;
  logic       wb_write;
  logic [2:0] wb_reg;
  logic [7:0] wb_data;
  logic       flag_z, flag_c;

  exec_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .src_a(src_a), .src_b(src_b), .dest(dest), .dmaddr(dmaddr),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_re(dm_re), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Asynchronous-read data memory
  logic [7:0] mem [16];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       wb;
    bit [2:0] rg;
    bit [7:0] data;
    bit       fupd, z, c;
    bit       we, re;
    bit [3:0] addr;
    bit [7:0] wdata;
  } slot_t;

  slot_t    sched [32];
  int       cyc = 0;
  int       busy_until = 0;
  bit [7:0] model_mem [16];
  bit       cur_wb = 0;
  bit [2:0] cur_rg = 0;
  bit [7:0] cur_data = 0;
  bit       mz = 0, mc = 0;

  // Expected outputs for an instruction accepted at edge e appear in cycle e+k.
  function automatic void model_accept(int e);
    bit [7:0] a, b, p;
    bit [8:0] r;
    bit       c;
    int       s1, s2, s9;
    a = operand_a;
    b = operand_b;
`ifdef EXEC_FWD_EN
    if (cur_wb && cur_rg == src_a) a = cur_data;
    if (cur_wb && cur_rg == src_b) b = cur_data;
`endif
    s1 = (e + 1) % 32;
    s2 = (e + 2) % 32;
    s9 = (e + 9) % 32;
    busy_until = e + 1;
    r = 0;
    c = 0;
    if (opcode >= 1 && opcode <= 9) begin
      case (opcode)
        1: begin r = a + b; c = r[8]; end
        2: begin r = 9'(a - b); c = (a < b); end
        3: r = a & b;
        4: r = a | b;
        5: r = a ^ b;
        6: r = 9'(8'(~a));
        7: begin r = 9'(8'(a * 2)); c = a[7]; end
        8: begin r = a / 2; c = a[0]; end
        default: r = a;
      endcase
      sched[s1].wb = 1; sched[s1].rg = dest; sched[s1].data = r[7:0];
      sched[s1].fupd = 1; sched[s1].z = (r[7:0] == 0); sched[s1].c = c;
    end else if (opcode == 10) begin
      sched[s1].re = 1; sched[s1].addr = dmaddr;
      sched[s2].wb = 1; sched[s2].rg = dest; sched[s2].data = model_mem[dmaddr];
      busy_until = e + 2;
    end else if (opcode == 11) begin
      sched[s1].we = 1; sched[s1].addr = dmaddr; sched[s1].wdata = a;
      model_mem[dmaddr] = a;
    end else if (opcode == 12) begin
      p = 8'((a * b) % 256);
      sched[s9].wb = 1; sched[s9].rg = dest; sched[s9].data = p;
      sched[s9].fupd = 1; sched[s9].z = (p == 0); sched[s9].c = 0;
      busy_until = e + 9;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) sched[i] = '{default: 0};
      busy_until = 0;
    end else if (in_valid && cyc >= busy_until) begin
      model_accept(cyc);
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin : compare
    slot_t s;
    s = sched[cyc % 32];
    sched[cyc % 32] = '{default: 0};
    cur_wb = s.wb; cur_rg = s.rg; cur_data = s.data;
    if (reset) begin
      mz = 0; mc = 0; cur_wb = 0;
    end else begin
      check("in_ready", in_ready, 32'(cyc >= busy_until));
      check("wb_write", wb_write, s.wb);
      if (s.wb) begin
        check("wb_reg", wb_reg, s.rg);
        check("wb_data", wb_data, s.data);
      end
      check("dm_we", dm_we, s.we);
      check("dm_re", dm_re, s.re);
      if (s.we || s.re) check("dm_addr", dm_addr, s.addr);
      if (s.we) check("dm_wdata", dm_wdata, s.wdata);
      if (s.fupd) begin mz = s.z; mc = s.c; end
      check("flag_z", flag_z, mz);
      check("flag_c", flag_c, mc);
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                      input logic [3:0] ad);
    bit done;
    done = 0;
    opcode = op; operand_a = a; operand_b = b;
    src_a = sa; src_b = sb; dest = d; dmaddr = ad;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      done = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_write"}, wb_write, 0);
    check({tag, "_wb_reg"}, wb_reg, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_dm_we"}, dm_we, 0);
    check({tag, "_dm_re"}, dm_re, 0);
    check({tag, "_dm_addr"}, dm_addr, 0);
    check({tag, "_dm_wdata"}, dm_wdata, 0);
    check({tag, "_flags"}, {flag_z, flag_c}, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      model_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // ALU basics and flags
    send(4'h1, 8'h22, 8'h44, 3'd1, 3'd2, 3'd3, 4'd0);
    check("add_wb_write", wb_write, 1);
    check("add_wb_reg", wb_reg, 3);
    check("add_wb_data", wb_data, 8'h66);
    check("add_zc", {flag_z, flag_c}, 2'b00);
    send(4'h2, 8'h22, 8'h44, 3'd1, 3'd2, 3'd4, 4'd0);
    check("sub_wb_data", wb_data, 8'hDE);
    check("sub_zc", {flag_z, flag_c}, 2'b01);
    send(4'h1, 8'hFF, 8'h01, 3'd1, 3'd2, 3'd2, 4'd0);
    check("add_wrap_data", wb_data, 8'h00);
    check("add_wrap_zc", {flag_z, flag_c}, 2'b11);

    // MUL with a second instruction held on in_valid
    send(4'hC, 8'h0C, 8'h0B, 3'd1, 3'd1, 3'd5, 4'd0);
    opcode = 4'h1; operand_a = 8'h01; operand_b = 8'h02;
    src_a = 3'd6; src_b = 3'd6; dest = 3'd7; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("mul_busy_ready", in_ready, 0);
      check("mul_busy_wb", wb_write, 0);
      @(negedge clk);
    end
    check("mul_done_ready", in_ready, 1);
    check("mul_wb_write", wb_write, 1);
    check("mul_wb_reg", wb_reg, 5);
    check("mul_wb_data", wb_data, 8'h84);
    check("mul_zc", {flag_z, flag_c}, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_add_wb", {wb_write, wb_reg, wb_data}, {1'b1, 3'd7, 8'h03});

    // STORE then LOAD the same address
    send(4'hB, 8'hAA, 8'h00, 3'd0, 3'd0, 3'd0, 4'd4);
    check("store_we", dm_we, 1);
    check("store_addr", dm_addr, 4);
    check("store_wdata", dm_wdata, 8'hAA);
    check("store_no_wb", wb_write, 0);
    send(4'hA, 8'h00, 8'h00, 3'd0, 3'd0, 3'd6, 4'd4);
    check("load_re", dm_re, 1);
    check("load_addr", dm_addr, 4);
    check("load_ready_low", in_ready, 0);
    @(negedge clk);
    check("load_wb", {wb_write, wb_reg, wb_data}, {1'b1, 3'd6, 8'hAA});
    check("load_re_off", dm_re, 0);

    // Read-during-write hazard: forwarded only when EXEC_FWD_EN is defined
    send(4'h1, 8'h22, 8'h44, 3'd2, 3'd3, 3'd1, 4'd0);
    send(4'h9, 8'h22, 8'h00, 3'd1, 3'd0, 3'd2, 4'd0);
`ifdef EXEC_FWD_EN
    check("fwd_mov", wb_data, 8'h66);
`else
    check("nofwd_mov", wb_data, 8'h22);
`endif

    // Reset in the middle of a multiply
    send(4'hC, 8'h0C, 8'h0B, 3'd0, 3'd0, 3'd5, 4'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_all_zero("midmul_reset");
    @(negedge clk);
    reset = 1'b0;
    saw = 0;
    repeat (12) begin
      if (wb_write || dm_we || dm_re) saw = 1;
      @(negedge clk);
    end
    check("no_activity_after_reset", saw, 0);

    // Randomized stream, including idle gaps with junk on the inputs
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          opcode = 4'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
          src_a = 3'($urandom); src_b = 3'($urandom); dest = 3'($urandom);
          dmaddr = 4'($urandom);
          @(negedge clk);
        end
      end
      send(4'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
           3'($urandom), 4'($urandom));
    end
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 8-bit processor pipeline, directly downstream of the register-file read stage.
- Takes operand_a/operand_b plus the pass-through opcode, dest, dmaddr and source addresses, and performs the ALU op, load, store or multi-cycle multiply.
- Drives the data-memory port.
- Returns a registered writeback triple (wb_write, wb_reg, wb_data) to the register file's write, wR and dataIn inputs.

Parameters:
- DATA_W, 8, datapath width
- REG_AW, 3, register address width
- DM_AW, 4, data-memory address width
- OPC_W, 4, opcode width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- opcode  in  OPC_W  operation
- operand_a  in  DATA_W  value of source A
- operand_b  in  DATA_W  value of source B
- src_a  in  REG_AW  address of source A (forwarding compare)
- src_b  in  REG_AW  address of source B (forwarding compare)
- dest  in  REG_AW  destination register
- dmaddr  in  DM_AW  data-memory address
- dm_addr  out  DM_AW  registered memory address
- dm_we  out  1  registered store strobe
- dm_re  out  1  registered load strobe
- dm_wdata  out  DATA_W  store data
- dm_rdata  in  DATA_W  load data, valid in the cycle dm_re is high (asynchronous-read memory)
- wb_write  out  1  register-file write enable, one-cycle pulse
- wb_reg  out  REG_AW  writeback address
- wb_data  out  DATA_W  writeback data
- flag_z  out  1  zero flag of last writing op
- flag_c  out  1  carry/borrow of last ADD/SUB/SHL/SHR

Behaviour:
- Accept occurs on the rising edge when in_valid && in_ready.
- Opcode map:
  - 0 NOP
  - 1 ADD a+b
  - 2 SUB a-b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT a
  - 7 SHL a by 1
  - 8 SHR a by 1 (logical)
  - 9 MOV a
  - A LOAD
  - B STORE
  - C MUL (low 8 bits of a*b)
  - D–F reserved, treated as NOP
- States: IDLE, LOAD_WAIT, MUL_BUSY. in_ready = (state==IDLE).
- ALU ops 1–9:
  - Accept at edge N; wb_write=1 with wb_reg=dest and wb_data=result during cycle N+1 only.
  - Flags update at the same edge.
  - ADD: c = carry out. SUB: c = borrow (a<b). SHL: c = a[7]. SHR: c = a[0]. Ops 3,4,5,6,9 clear c.
  - z = (result==0).
- LOAD:
  - Accept at edge N → state LOAD_WAIT; dm_re=1, dm_addr=dmaddr during cycle N+1.
  - At edge N+1, capture dm_rdata → wb_write pulse in cycle N+2 to dest; state back to IDLE.
  - Flags unchanged.
- STORE:
  - Accept at edge N → dm_we=1, dm_addr=dmaddr, dm_wdata=operand_a during cycle N+1 only.
  - No writeback. State stays IDLE.
- MUL:
  - Accept at edge N latches a, b; state MUL_BUSY.
  - Shift-add over 8 iterations on edges N+1..N+8, with a 3-bit iteration counter.
  - Writeback pulse in cycle N+9. in_ready is low in cycles N+1..N+8 and high again in cycle N+9.
  - z updated, c cleared.
- NOP/reserved: no writeback, no memory strobe, flags unchanged.
- in_valid low or in_ready low: no state change; held upstream signals are ignored.
- Writeback of the previous instruction and acceptance of the next may coincide (back-to-back ALU ops give one wb pulse per cycle).
- Reset (asynchronous, any state, including mid-MUL or LOAD_WAIT):
  - State → IDLE; counter → 0.
  - All outputs → 0: wb_write, wb_reg, wb_data, dm_we, dm_re, dm_addr, dm_wdata, flag_z, flag_c. in_ready reads 1.
  - Any in-flight result is discarded; no writeback or memory strobe follows reset release.
- Arithmetic: all results truncated to DATA_W, unsigned.

Optional Feature:
- Macro EXEC_FWD_EN.
- When defined: at acceptance, if wb_write is high and wb_reg==src_a, the stage uses wb_data in place of operand_a; likewise src_b/operand_b. This covers the read-during-write hazard of the combinational register read.
- When undefined: operands are used exactly as presented, and software must separate dependent instructions by one slot.

Test Plan:
- Reset (r1=0x22, r2=0x44), ADD a=0x22 b=0x44 dest=3 → cycle after accept wb_write=1, wb_reg=3, wb_data=0x66, z=0, c=0.
- SUB a=0x22 b=0x44 → wb_data=0xDE, c=1; then ADD a=0xFF b=0x01 → wb_data=0x00, z=1, c=1.
- MUL a=0x0C b=0x0B dest=5 → in_ready low for 8 cycles, wb_data=0x84 in the 9th cycle after accept; a second instruction held on in_valid is accepted only then.
- STORE a=0xAA dmaddr=4, then LOAD dmaddr=4 dest=6 → dm_we pulse with dm_addr=4 and dm_wdata=0xAA; dm_re the cycle after LOAD accept; wb_data=0xAA to reg 6 one cycle later.
- Assert reset at MUL cycle 4 → all outputs 0, in_ready=1, and no wb_write pulse afterward.
- EXEC_FWD_EN defined: ADD dest=1 result 0x66, then next-cycle MOV with src_a=1 and stale operand_a=0x22 → wb_data=0x66; with the macro undefined → 0x22.
